// File: rtl/emboss_nxn_dir_pkg.sv
// Shared video definitions for the emboss stage.
// Holds the neighbour-mode encoding, the pipeline latency and the RGB-565
// packing helper.
package emboss_nxn_dir_pkg;

    typedef enum logic [1:0] {
        MODE_BYPASS = 2'd0,
        MODE_H      = 2'd1,
        MODE_V      = 2'd2,
        MODE_D      = 2'd3
    } mode_e;

    localparam int PIPE_LAT = 2;

    // Takes the six most significant bits of a luma value and replicates them
    // into R5:G6:B5 so a grey level maps onto a grey display colour.
    function automatic logic [15:0] pack_rgb565(input logic [5:0] msb6);
        return {msb6[5:1], msb6, msb6[5:1]};
    endfunction

endpackage

// File: rtl/emboss_nxn_dir_line_buffer_1r1w.sv
// One-line pixel store with a synchronous, read-before-write read port.
// Ports:
//   clk, rst_n      clock and asynchronous active-low reset (read register only)
//   i_re, i_raddr   read enable and address; data appears on o_rdata next clock
//   i_we, i_waddr,
//   i_wdata         write enable, address and data
//   o_rdata         registered read data; holds its value when i_re is low
module line_buffer_1r1w #(
    parameter int DEPTH = 1024,
    parameter int WIDTH = 8,
    parameter int AW    = 10
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             i_re,
    input  logic [AW-1:0]    i_raddr,
    input  logic             i_we,
    input  logic [AW-1:0]    i_waddr,
    input  logic [WIDTH-1:0] i_wdata,
    output logic [WIDTH-1:0] o_rdata
);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [WIDTH-1:0] rdata_q;
    logic [WIDTH-1:0] rdata_d;

    // The read samples the array before this clock's write lands, so a
    // same-address access returns the previous line's pixel.
    always_comb begin
        rdata_d = rdata_q;
        if (i_re) begin
            rdata_d = mem[i_raddr];
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rdata_q <= '0;
        end else begin
            rdata_q <= rdata_d;
        end
    end

    always_ff @(posedge clk) begin
        if (i_we) begin
            mem[i_waddr] <= i_wdata;
        end
    end

    assign o_rdata = rdata_q;

endmodule

// File: rtl/emboss_nxn_dir.sv
// Directional emboss on a streamed luma pixel: neighbour - current + offset,
// clamped and packed to RGB-565. Neighbour is left, above or upper-left,
// selected once per frame; mode 0 passes the luma straight through.
// Ports:
//   clk, rst_n          pixel clock, asynchronous active-low reset
//   i_mode              0 bypass, 1 left, 2 above, 3 upper-left (sampled while i_VSYNC low)
//   i_offset            unsigned bias added to the difference
//   i_HSYNC, i_VSYNC    active-low syncs
//   i_BLANK             1 = active pixel
//   i_Y0                luma pixel
//   H_SYNC, V_SYNC,
//   BLANK               input controls delayed by two clocks
//   display_data        RGB-565 result, zero during blanking
module emboss_nxn_dir
    import emboss_nxn_dir_pkg::*;
#(
    parameter int DATA_W    = 8,
    parameter int MAX_WIDTH = 1024,
    parameter int COL_W     = 10
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic [1:0]        i_mode,
    input  logic [DATA_W-1:0] i_offset,
    input  logic              i_HSYNC,
    input  logic              i_VSYNC,
    input  logic              i_BLANK,
    input  logic [DATA_W-1:0] i_Y0,
    output logic              H_SYNC,
    output logic              V_SYNC,
    output logic              BLANK,
    output logic [15:0]       display_data
);

    localparam int VW = DATA_W + 2;
    // One extra bit so the column can sit at MAX_WIDTH when it is a power of two.
    localparam logic [COL_W:0] MAX_COL = (COL_W + 1)'(MAX_WIDTH);
    localparam logic [COL_W:0] COL_ONE = (COL_W + 1)'(1);

    // Front-end state
    logic [COL_W:0]    col_q, col_d;
    logic              row_valid_q, row_valid_d;
    mode_e             mode_q, mode_d;
    logic [DATA_W-1:0] prev_q, prev_d;

    // Stage 1
    logic [DATA_W-1:0] cur_s1_q, cur_s1_d;
    logic [DATA_W-1:0] left_s1_q, left_s1_d;
    logic [DATA_W-1:0] off_s1_q, off_s1_d;
    mode_e             mode_s1_q, mode_s1_d;
    logic              col0_s1_q, col0_s1_d;
    logic              over_s1_q, over_s1_d;
    logic              rv_s1_q, rv_s1_d;
    logic              blank_s1_q, blank_s1_d;
    logic              hsync_s1_q, hsync_s1_d;
    logic              vsync_s1_q, vsync_s1_d;
    logic [DATA_W-1:0] ul_q, ul_d;

    // Stage 2
    logic [15:0]       display_q, display_d;
    logic              blank_s2_q, blank_s2_d;
    logic              hsync_s2_q, hsync_s2_d;
    logic              vsync_s2_q, vsync_s2_d;

    logic              in_range;
    logic              lb_en;
    logic [DATA_W-1:0] above;
    logic [DATA_W-1:0] nb;
    logic [VW-1:0]     v;
    logic [DATA_W-1:0] c;
    logic              unused_c_lsb;

    assign in_range = (col_q < MAX_COL);
    assign lb_en    = i_BLANK && in_range;

    line_buffer_1r1w #(
        .DEPTH (MAX_WIDTH),
        .WIDTH (DATA_W),
        .AW    (COL_W)
    ) u_line_buf (
        .clk     (clk),
        .rst_n   (rst_n),
        .i_re    (lb_en),
        .i_raddr (col_q[COL_W-1:0]),
        .i_we    (lb_en),
        .i_waddr (col_q[COL_W-1:0]),
        .i_wdata (i_Y0),
        .o_rdata (above)
    );

    always_comb begin
        col_d = col_q;
        if (!i_BLANK) begin
            col_d = '0;
        end else if (in_range) begin
            col_d = col_q + COL_ONE;
        end

        // blank_s1_q is i_BLANK one clock ago, so this is the falling edge of
        // i_BLANK after at least one active pixel.
        row_valid_d = row_valid_q;
        if (!i_VSYNC) begin
            row_valid_d = 1'b0;
        end else if (blank_s1_q && !i_BLANK) begin
            row_valid_d = 1'b1;
        end

        mode_d = i_VSYNC ? mode_q : mode_e'(i_mode);
        prev_d = i_BLANK ? i_Y0 : prev_q;

        cur_s1_d   = i_Y0;
        left_s1_d  = prev_q;
        off_s1_d   = i_offset;
        mode_s1_d  = mode_q;
        col0_s1_d  = (col_q == '0);
        over_s1_d  = !in_range;
        rv_s1_d    = row_valid_q;
        blank_s1_d = i_BLANK;
        hsync_s1_d = i_HSYNC;
        vsync_s1_d = i_VSYNC;

        // The line-buffer output belongs to the pixel now in stage 1; keeping
        // it for one more active pixel gives the upper-left neighbour.
        ul_d = blank_s1_q ? above : ul_q;

        nb = cur_s1_q;
        case (mode_s1_q)
            MODE_H: if (!col0_s1_q) nb = left_s1_q;
            MODE_V: if (rv_s1_q && !over_s1_q) nb = above;
            MODE_D: if (!col0_s1_q && rv_s1_q && !over_s1_q) nb = ul_q;
            default: nb = cur_s1_q;
        endcase

        // Two's-complement in VW bits: top bit is the sign, next bit flags > max.
        v = {2'b00, nb} - {2'b00, cur_s1_q} + {2'b00, off_s1_q};

        if (mode_s1_q == MODE_BYPASS) begin
            c = cur_s1_q;
        end else if (v[VW-1]) begin
            c = '0;
        end else if (v[VW-2]) begin
            c = '1;
        end else begin
            c = v[DATA_W-1:0];
        end

        display_d  = blank_s1_q ? pack_rgb565(c[DATA_W-1 -: 6]) : 16'h0000;
        blank_s2_d = blank_s1_q;
        hsync_s2_d = hsync_s1_q;
        vsync_s2_d = vsync_s1_q;
    end

    assign unused_c_lsb = ^c;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            col_q       <= '0;
            row_valid_q <= 1'b0;
            mode_q      <= MODE_BYPASS;
            prev_q      <= '0;
            cur_s1_q    <= '0;
            left_s1_q   <= '0;
            off_s1_q    <= '0;
            mode_s1_q   <= MODE_BYPASS;
            col0_s1_q   <= 1'b0;
            over_s1_q   <= 1'b0;
            rv_s1_q     <= 1'b0;
            blank_s1_q  <= 1'b0;
            hsync_s1_q  <= 1'b0;
            vsync_s1_q  <= 1'b0;
            ul_q        <= '0;
            display_q   <= '0;
            blank_s2_q  <= 1'b0;
            hsync_s2_q  <= 1'b0;
            vsync_s2_q  <= 1'b0;
        end else begin
            col_q       <= col_d;
            row_valid_q <= row_valid_d;
            mode_q      <= mode_d;
            prev_q      <= prev_d;
            cur_s1_q    <= cur_s1_d;
            left_s1_q   <= left_s1_d;
            off_s1_q    <= off_s1_d;
            mode_s1_q   <= mode_s1_d;
            col0_s1_q   <= col0_s1_d;
            over_s1_q   <= over_s1_d;
            rv_s1_q     <= rv_s1_d;
            blank_s1_q  <= blank_s1_d;
            hsync_s1_q  <= hsync_s1_d;
            vsync_s1_q  <= vsync_s1_d;
            ul_q        <= ul_d;
            display_q   <= display_d;
            blank_s2_q  <= blank_s2_d;
            hsync_s2_q  <= hsync_s2_d;
            vsync_s2_q  <= vsync_s2_d;
        end
    end

    assign H_SYNC       = hsync_s2_q;
    assign V_SYNC       = vsync_s2_q;
    assign BLANK        = blank_s2_q;
    assign display_data = display_q;

endmodule

// File: tb/tb_emboss_nxn_dir.sv
module tb_emboss_nxn_dir;

    localparam int DW   = 8;
    localparam int MAXW = 8;
    localparam int CW   = 3;
    localparam int LAT  = 2;

    logic          clk = 1'b0;
    logic          rst_n = 1'b0;
    logic [1:0]    i_mode = 2'd0;
    logic [DW-1:0] i_offset = '0;
    logic          i_HSYNC = 1'b1;
    logic          i_VSYNC = 1'b1;
    logic          i_BLANK = 1'b0;
    logic [DW-1:0] i_Y0 = '0;
    logic          H_SYNC, V_SYNC, BLANK;
    logic [15:0]   display_data;

    emboss_nxn_dir #(.DATA_W(DW), .MAX_WIDTH(MAXW), .COL_W(CW)) dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .i_mode       (i_mode),
        .i_offset     (i_offset),
        .i_HSYNC      (i_HSYNC),
        .i_VSYNC      (i_VSYNC),
        .i_BLANK      (i_BLANK),
        .i_Y0         (i_Y0),
        .H_SYNC       (H_SYNC),
        .V_SYNC       (V_SYNC),
        .BLANK        (BLANK),
        .display_data (display_data)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    typedef struct {
        int          due;
        logic [18:0] exp;
    } exp_t;

    exp_t sbq[$];
    exp_t e;
    logic [18:0] got;
    int errors = 0;
    int checks = 0;

    // Reference model state: frame-level view of the video stream.
    int g_mode = 0;
    int g_off  = 0;
    int m_col  = 0;   // column of the next active pixel in this line
    int m_rows = 0;   // completed lines since frame start or reset
    int m_mode = 0;   // mode latched for the current frame
    int m_last = 0;   // previous active pixel on this line
    int m_cur[MAXW];
    int m_prev[MAXW];
    int px[16];

    function automatic logic [15:0] pack(input int c);
        logic [4:0] r;
        logic [5:0] g;
        r = 5'(c >> 3);
        g = 6'(c >> 2);
        return {r, g, r};
    endfunction

    task automatic commit_line();
        for (int i = 0; i < m_col && i < MAXW; i++) m_prev[i] = m_cur[i];
    endtask

    task automatic model_reset();
        commit_line();
        m_col  = 0;
        m_rows = 0;
        m_mode = 0;
    endtask

    task automatic model_step(input logic hs, input logic vs, input logic bl, input int y);
        logic [15:0] dv;
        exp_t        item;
        int          nb, v, c;
        dv = 16'h0000;
        if (bl) begin
            nb = y;
            if (m_mode == 1 && m_col > 0) nb = m_last;
            else if (m_mode == 2 && m_rows > 0 && m_col < MAXW) nb = m_prev[m_col];
            else if (m_mode == 3 && m_rows > 0 && m_col > 0 && m_col < MAXW) nb = m_prev[m_col-1];
            v = nb - y + g_off;
            if (m_mode == 0) c = y;
            else if (v < 0) c = 0;
            else if (v > 255) c = 255;
            else c = v;
            dv = pack(c);
            if (m_col < MAXW) m_cur[m_col] = y;
            m_last = y;
            m_col++;
        end else begin
            if (m_col > 0) begin
                commit_line();
                m_rows++;
            end
            m_col = 0;
        end
        if (!vs) begin
            m_rows = 0;
            m_mode = g_mode;
        end
        item.due = cyc + LAT;
        item.exp = {hs, vs, bl, dv};
        sbq.push_back(item);
    endtask

    task automatic apply(input logic hs, input logic vs, input logic bl, input int y);
        i_HSYNC  = hs;
        i_VSYNC  = vs;
        i_BLANK  = bl;
        i_Y0     = DW'(y);
        i_mode   = 2'(g_mode);
        i_offset = DW'(g_off);
        if (rst_n) model_step(hs, vs, bl, y);
    endtask

    task automatic drive(input logic hs, input logic vs, input logic bl, input int y);
        @(negedge clk);
        apply(hs, vs, bl, y);
    endtask

    task automatic vsync();
        for (int i = 0; i < 3; i++) drive(1'b1, 1'b0, 1'b0, int'($urandom_range(0, 255)));
        for (int i = 0; i < 2; i++) drive(1'b1, 1'b1, 1'b0, int'($urandom_range(0, 255)));
    endtask

    task automatic line(input int n);
        for (int i = 0; i < 2; i++) drive(1'b0, 1'b1, 1'b0, int'($urandom_range(0, 255)));
        drive(1'b1, 1'b1, 1'b0, int'($urandom_range(0, 255)));
        for (int i = 0; i < n; i++) drive(1'b1, 1'b1, 1'b1, px[i]);
        for (int i = 0; i < 2; i++) drive(1'b1, 1'b1, 1'b0, int'($urandom_range(0, 255)));
    endtask

    task automatic check_zero(input string name);
        checks++;
        got = {H_SYNC, V_SYNC, BLANK, display_data};
        if (got !== 19'h0) begin
            errors++;
            $display("FAIL %s: got=%h expected=%h", name, got, 19'h0);
        end
    endtask

    // Monitor: pops the expected word due this cycle and compares.
    initial begin
        forever begin
            @(negedge clk);
            if (rst_n && sbq.size() > 0 && sbq[0].due <= cyc) begin
                e = sbq.pop_front();
                got = {H_SYNC, V_SYNC, BLANK, display_data};
                checks++;
                if (e.due != cyc) begin
                    errors++;
                    $display("FAIL latency: cycle=%0d due=%0d", cyc, e.due);
                end else if (got !== e.exp) begin
                    errors++;
                    $display("FAIL out cyc=%0d {hs,vs,blank,data}: got=%h expected=%h", cyc, got, e.exp);
                end
            end
        end
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int w, rows;

        // Reset held with active stimulus
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            apply(1'b1, 1'b1, 1'b1, int'($urandom_range(0, 255)));
            check_zero("reset_hold");
        end
        @(negedge clk);
        rst_n = 1'b1;
        apply(1'b1, 1'b1, 1'b1, 77);
        for (int i = 0; i < 3; i++) drive(1'b1, 1'b1, 1'b1, int'($urandom_range(0, 255)));
        for (int i = 0; i < 2; i++) drive(1'b1, 1'b1, 1'b0, 0);

        // Horizontal ramp
        g_mode = 1; g_off = 128;
        vsync();
        px[0] = 10; px[1] = 20; px[2] = 30;
        line(3);

        // Vertical, both orderings
        g_mode = 2; g_off = 128;
        vsync();
        for (int i = 0; i < 5; i++) px[i] = 50;
        line(5);
        for (int i = 0; i < 5; i++) px[i] = 200;
        line(5);
        vsync();
        line(5);
        for (int i = 0; i < 5; i++) px[i] = 50;
        line(5);

        // Diagonal 4x4 ramp
        g_mode = 3; g_off = 0;
        vsync();
        for (int r = 0; r < 4; r++) begin
            for (int c = 0; c < 4; c++) px[c] = 16 * r + c;
            line(4);
        end

        // Mid-frame mode change waits for the next vsync; then bypass
        g_mode = 1; g_off = 100;
        vsync();
        for (int i = 0; i < 6; i++) px[i] = int'($urandom_range(0, 255));
        line(6);
        g_mode = 2;
        line(6);
        line(6);
        vsync();
        line(6);
        for (int i = 0; i < 6; i++) px[i] = int'($urandom_range(0, 255));
        line(6);
        g_mode = 0;
        vsync();
        line(6);

        // Lines longer than the line buffer
        g_mode = 2; g_off = 77;
        vsync();
        for (int r = 0; r < 3; r++) begin
            for (int i = 0; i < 12; i++) px[i] = int'($urandom_range(0, 255));
            line(12);
        end

        // Random frames
        for (int f = 0; f < 10; f++) begin
            g_mode = int'($urandom_range(0, 3));
            g_off  = int'($urandom_range(0, 255));
            w      = int'($urandom_range(1, 12));
            rows   = int'($urandom_range(1, 4));
            vsync();
            for (int r = 0; r < rows; r++) begin
                if (r == 1 && $urandom_range(0, 1) == 1) g_mode = int'($urandom_range(0, 3));
                for (int i = 0; i < w; i++) px[i] = int'($urandom_range(0, 255));
                line(w);
            end
        end

        // Asynchronous reset in the middle of a line
        g_mode = 1; g_off = 30;
        vsync();
        for (int i = 0; i < 5; i++) px[i] = int'($urandom_range(0, 255));
        line(5);
        drive(1'b1, 1'b1, 1'b0, 0);
        for (int i = 0; i < 3; i++) drive(1'b1, 1'b1, 1'b1, int'($urandom_range(0, 255)));
        @(posedge clk);
        #2;
        rst_n = 1'b0;
        #1;
        check_zero("async_reset");
        sbq.delete();
        model_reset();
        for (int i = 0; i < 3; i++) drive(1'b1, 1'b1, 1'b0, 0);
        @(negedge clk);
        rst_n = 1'b1;
        apply(1'b1, 1'b1, 1'b0, 0);
        g_mode = 3; g_off = 200;
        for (int i = 0; i < 4; i++) px[i] = int'($urandom_range(0, 255));
        line(4);
        line(4);
        vsync();
        for (int r = 0; r < 3; r++) begin
            for (int i = 0; i < 7; i++) px[i] = int'($urandom_range(0, 255));
            line(7);
        end

        for (int k = 0; k < 10 && sbq.size() > 0; k++) @(negedge clk);
        @(negedge clk);
        if (sbq.size() > 0) begin
            checks++;
            errors++;
            $display("FAIL drain: pending=%0d expected=0", sbq.size());
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
